// File: rtl/wb_spi_slave_ctrl.sv
// rtl/wb_spi_slave_ctrl.sv - Wishbone controller that feeds and drains an SPI slave byte engine
//
// Buffers CPU TX bytes and received RX bytes in FIFOs, loads one TX byte per
// SPI byte slot, tracks frames on the chip select, keeps sticky error flags
// and drives one level interrupt.
//
// Ports:
//   clk_i, rst_i            system clock, synchronous active-high reset
//   wb_cyc_i .. wb_stall_o  pipelined Wishbone slave, 4 registers at adr[3:2]
//   spi_tx_dv_o/_byte_o     one-cycle load strobe and byte for the next SPI slot
//   spi_rx_dv_i/_byte_i     byte-complete strobe and received byte from the engine
//   cs_i                    asynchronous active-low chip select from the pad
//   irq_o                   registered level interrupt

module wb_spi_slave_ctrl #(
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] IDLE_BYTE  = 8'hFF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_stall_o,
  output logic        spi_tx_dv_o,
  output logic [7:0]  spi_tx_byte_o,
  input  logic        spi_rx_dv_i,
  input  logic [7:0]  spi_rx_byte_i,
  input  logic        cs_i,
  output logic        irq_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   LVL_ONE = 1;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_WAIT} state_t;

  state_t state;

  // FIFO storage and bookkeeping
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
  logic [AW:0]   tx_level, rx_level;
  logic          tx_full, tx_empty, rx_full, rx_empty;

  // Registers and flags
  logic [2:0]  ctrl;
  logic        enable;
  logic        rx_ovf, tx_udr, tx_ovf, frame_done;
  logic [15:0] frame_cnt;

  // Chip select synchronizer
  logic       cs_meta, cs_s, cs_prev, armed;
  logic [1:0] settle;
  logic       cs_fall, cs_rise;

  // Decode and event strobes
  logic       req, data_wr, data_rd, stat_wr, ctrl_wr;
  logic [1:0] reg_sel;
  logic       slot_load, rx_cap, frame_end;
  logic       tx_push, tx_pop, rx_push, rx_pop;
  logic [31:0] status, rdata;
  logic        unused_bits;

  assign wb_err_o   = 1'b0;
  assign wb_stall_o = 1'b0;
  assign unused_bits = ^{wb_adr_i[1:0], wb_dat_i[31:8]};

  assign enable   = ctrl[0];
  assign tx_full  = tx_level[AW];
  assign rx_full  = rx_level[AW];
  assign tx_empty = (tx_level == '0);
  assign rx_empty = (rx_level == '0);

  // The synchronizer flops reset to "deselected". A low cs held through reset
  // must not look like a falling edge, so falls only count once the real pad
  // level has been seen high after reset (armed).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cs_meta <= 1'b1;
      cs_s    <= 1'b1;
      cs_prev <= 1'b1;
      settle  <= 2'd0;
      armed   <= 1'b0;
    end else begin
      cs_meta <= cs_i;
      cs_s    <= cs_meta;
      cs_prev <= cs_s;
      if (settle != 2'd2) settle <= settle + 2'd1;
      if (settle == 2'd2 && cs_s) armed <= 1'b1;
    end
  end

  assign cs_fall = armed & cs_prev & ~cs_s;
  assign cs_rise = ~cs_prev & cs_s;

  // Wishbone request decode
  assign req     = wb_cyc_i & wb_stb_i;
  assign reg_sel = wb_adr_i[3:2];
  assign data_wr = req &  wb_we_i & (reg_sel == 2'd0);
  assign data_rd = req & ~wb_we_i & (reg_sel == 2'd0);
  assign stat_wr = req &  wb_we_i & (reg_sel == 2'd1);
  assign ctrl_wr = req &  wb_we_i & (reg_sel == 2'd2);

  // Slot and capture events; a rise coinciding with a received byte ends the
  // frame instead of opening another slot.
  assign slot_load = enable & (((state == ST_IDLE) & cs_fall) |
                               ((state == ST_WAIT) & spi_rx_dv_i & ~cs_rise));
  assign rx_cap    = enable & (state == ST_WAIT) & spi_rx_dv_i;
  assign frame_end = enable & ((state == ST_WAIT) | (state == ST_LOAD)) & cs_rise;

  // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
  assign tx_pop  = slot_load & ~tx_empty;
  assign tx_push = data_wr & (~tx_full | tx_pop);
  assign rx_pop  = data_rd & ~rx_empty;
  assign rx_push = rx_cap & (~rx_full | rx_pop);

  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= wb_dat_i[7:0];
    if (rx_push) rx_mem[rx_wr_ptr] <= spi_rx_byte_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_level  <= '0;
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_level  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + PTR_ONE;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PTR_ONE;
      if (tx_push && !tx_pop) tx_level <= tx_level + LVL_ONE;
      else if (!tx_push && tx_pop) tx_level <= tx_level - LVL_ONE;

      if (rx_push) rx_wr_ptr <= rx_wr_ptr + PTR_ONE;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PTR_ONE;
      if (rx_push && !rx_pop) rx_level <= rx_level + LVL_ONE;
      else if (!rx_push && rx_pop) rx_level <= rx_level - LVL_ONE;
    end
  end

  // Slot sequencer; spi_tx_byte_o holds between loads.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= ST_IDLE;
      spi_tx_dv_o   <= 1'b0;
      spi_tx_byte_o <= 8'h00;
      frame_cnt     <= 16'h0000;
    end else begin
      spi_tx_dv_o <= slot_load;
      if (slot_load) spi_tx_byte_o <= tx_empty ? IDLE_BYTE : tx_mem[tx_rd_ptr];
      if (rx_cap && frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 16'd1;

      if (!enable) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (cs_fall) begin
              state     <= ST_LOAD;
              frame_cnt <= 16'h0000;
            end
          end
          ST_LOAD: state <= cs_rise ? ST_IDLE : ST_WAIT;
          ST_WAIT: begin
            if (cs_rise)          state <= ST_IDLE;
            else if (spi_rx_dv_i) state <= ST_LOAD;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Sticky flags: a set in the same cycle as a W1C clear wins.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl       <= 3'b000;
      rx_ovf     <= 1'b0;
      tx_udr     <= 1'b0;
      tx_ovf     <= 1'b0;
      frame_done <= 1'b0;
      irq_o      <= 1'b0;
    end else begin
      if (ctrl_wr) ctrl <= wb_dat_i[2:0];
      if (stat_wr) begin
        if (wb_dat_i[4]) rx_ovf     <= 1'b0;
        if (wb_dat_i[5]) tx_udr     <= 1'b0;
        if (wb_dat_i[6]) tx_ovf     <= 1'b0;
        if (wb_dat_i[7]) frame_done <= 1'b0;
      end
      if (rx_cap && rx_full && !rx_pop)    rx_ovf     <= 1'b1;
      if (slot_load && tx_empty)           tx_udr     <= 1'b1;
      if (data_wr && tx_full && !tx_pop)   tx_ovf     <= 1'b1;
      if (frame_end)                       frame_done <= 1'b1;
      irq_o <= (ctrl[1] & ~rx_empty) | (ctrl[2] & frame_done) | rx_ovf | tx_ovf | tx_udr;
    end
  end

  always_comb begin
    status = 32'h0;
    status[0] = tx_full;
    status[1] = tx_empty;
    status[2] = rx_full;
    status[3] = rx_empty;
    status[4] = rx_ovf;
    status[5] = tx_udr;
    status[6] = tx_ovf;
    status[7] = frame_done;
    status[8] = ~cs_s;
    status[16 +: AW+1] = tx_level;
    status[24 +: AW+1] = rx_level;
  end

  always_comb begin
    rdata = 32'h0;
    case (reg_sel)
      2'd0: rdata = rx_empty ? 32'h0 : {24'h0, rx_mem[rx_rd_ptr]};
      2'd1: rdata = status;
      2'd2: rdata = {29'h0, ctrl};
      2'd3: rdata = {16'h0, frame_cnt};
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= 32'h0;
    end else begin
      wb_ack_o <= req;
      wb_dat_o <= (req && !wb_we_i) ? rdata : 32'h0;
    end
  end

endmodule

// File: tb/tb_wb_spi_slave_ctrl.sv
// tb/tb_wb_spi_slave_ctrl.sv - directed bench for wb_spi_slave_ctrl

module tb_wb_spi_slave_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [3:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, wb_err_o, wb_stall_o;
  logic        spi_tx_dv_o;
  logic [7:0]  spi_tx_byte_o;
  logic        spi_rx_dv_i;
  logic [7:0]  spi_rx_byte_i;
  logic        cs_i;
  logic        irq_o;

  int passed = 0;
  int total  = 0;
  int dv_count = 0;
  logic [7:0] last_byte = 8'h00;

  wb_spi_slave_ctrl #(.FIFO_DEPTH(8), .IDLE_BYTE(8'hFF)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_stall_o(wb_stall_o),
    .spi_tx_dv_o(spi_tx_dv_o), .spi_tx_byte_o(spi_tx_byte_o),
    .spi_rx_dv_i(spi_rx_dv_i), .spi_rx_byte_i(spi_rx_byte_i),
    .cs_i(cs_i), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (spi_tx_dv_o) begin
      dv_count  = dv_count + 1;
      last_byte = spi_tx_byte_o;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset(input logic cs);
    rst_i = 1'b1; cs_i = cs;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_adr_i = 4'h0; wb_dat_i = 32'h0;
    spi_rx_dv_i = 1'b0; spi_rx_byte_i = 8'h00;
    tick(); tick(); tick();
    rst_i = 1'b0;
    dv_count = 0;
  endtask

  task automatic wb_write(input logic [3:0] a, input logic [31:0] d);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = a; wb_dat_i = d;
    tick();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wb_read(input logic [3:0] a, output logic [31:0] d);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = a;
    tick();
    d = wb_dat_o;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    spi_rx_dv_i = 1'b1; spi_rx_byte_i = b;
    tick();
    spi_rx_dv_i = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic [31:0] d;
    do_reset(1'b1);
    total++; if ({wb_ack_o, spi_tx_dv_o, irq_o} !== 3'b000) $display("FAIL reset_outs: got %b expected 000", {wb_ack_o, spi_tx_dv_o, irq_o}); else passed++;
    total++; if (wb_dat_o !== 32'h0) $display("FAIL reset_dat: got %h expected 0", wb_dat_o); else passed++;
    wb_read(4'h4, d);
    total++; if (d !== 32'h0000_000A) $display("FAIL reset_status: got %h expected 0000000a", d); else passed++;
    wb_read(4'h8, d);
    total++; if (d !== 32'h0) $display("FAIL reset_ctrl: got %h expected 0", d); else passed++;
    wb_read(4'hC, d);
    total++; if (d !== 32'h0) $display("FAIL reset_fcnt: got %h expected 0", d); else passed++;
  endtask

  task automatic test_reset_cs_low();
    logic [31:0] d;
    do_reset(1'b0);
    wb_write(4'h8, 32'h1);
    repeat (10) tick();
    total++; if (dv_count !== 0) $display("FAIL cslow_no_slot: got %0d expected 0", dv_count); else passed++;
    cs_i = 1'b1;
    repeat (5) tick();
    cs_i = 1'b0;
    repeat (5) tick();
    total++; if (dv_count !== 1) $display("FAIL cslow_slot_after_fall: got %0d expected 1", dv_count); else passed++;
    total++; if (last_byte !== 8'hFF) $display("FAIL cslow_idle_byte: got %h expected ff", last_byte); else passed++;
    wb_read(4'h4, d);
    total++; if (d !== 32'h0000_012A) $display("FAIL cslow_status: got %h expected 0000012a", d); else passed++;
    cs_i = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_basic_frame();
    logic [31:0] d;
    do_reset(1'b1);
    wb_write(4'h0, 32'hA5);
    wb_write(4'h0, 32'h3C);
    wb_write(4'h8, 32'h1);
    cs_i = 1'b0;
    tick();
    total++; if (spi_tx_dv_o !== 1'b0) $display("FAIL basic_dv_early1: got %b expected 0", spi_tx_dv_o); else passed++;
    tick();
    total++; if (spi_tx_dv_o !== 1'b0) $display("FAIL basic_dv_early2: got %b expected 0", spi_tx_dv_o); else passed++;
    tick();
    total++; if ({spi_tx_dv_o, spi_tx_byte_o} !== {1'b1, 8'hA5}) $display("FAIL basic_first_slot: got %b/%h expected 1/a5", spi_tx_dv_o, spi_tx_byte_o); else passed++;
    tick();
    total++; if ({spi_tx_dv_o, spi_tx_byte_o} !== {1'b0, 8'hA5}) $display("FAIL basic_hold: got %b/%h expected 0/a5", spi_tx_dv_o, spi_tx_byte_o); else passed++;
    spi_rx_dv_i = 1'b1; spi_rx_byte_i = 8'h11;
    tick();
    spi_rx_dv_i = 1'b0;
    total++; if ({spi_tx_dv_o, spi_tx_byte_o} !== {1'b1, 8'h3C}) $display("FAIL basic_second_slot: got %b/%h expected 1/3c", spi_tx_dv_o, spi_tx_byte_o); else passed++;
    tick();
    spi_rx_dv_i = 1'b1; spi_rx_byte_i = 8'h22;
    tick();
    spi_rx_dv_i = 1'b0;
    total++; if ({spi_tx_dv_o, spi_tx_byte_o} !== {1'b1, 8'hFF}) $display("FAIL basic_idle_slot: got %b/%h expected 1/ff", spi_tx_dv_o, spi_tx_byte_o); else passed++;
    wb_read(4'h4, d);
    total++; if (d !== 32'h0200_0122) $display("FAIL basic_status_mid: got %h expected 02000122", d); else passed++;
    total++; if (irq_o !== 1'b1) $display("FAIL basic_irq_udr: got %b expected 1", irq_o); else passed++;
    cs_i = 1'b1;
    repeat (4) tick();
    wb_read(4'h4, d);
    total++; if (d !== 32'h0200_00A2) $display("FAIL basic_status_end: got %h expected 020000a2", d); else passed++;
    wb_read(4'hC, d);
    total++; if (d !== 32'd2) $display("FAIL basic_fcnt: got %h expected 2", d); else passed++;
    wb_read(4'h0, d);
    total++; if (d !== 32'h11) $display("FAIL basic_rx0: got %h expected 11", d); else passed++;
    wb_read(4'h0, d);
    total++; if (d !== 32'h22) $display("FAIL basic_rx1: got %h expected 22", d); else passed++;
    wb_read(4'h0, d);
    total++; if (d !== 32'h0) $display("FAIL basic_rx_empty: got %h expected 0", d); else passed++;
    total++; if (dv_count !== 3) $display("FAIL basic_slot_count: got %0d expected 3", dv_count); else passed++;
  endtask

  task automatic test_rx_overflow();
    logic [31:0] d;
    do_reset(1'b1);
    wb_write(4'h8, 32'h1);
    cs_i = 1'b0;
    repeat (5) tick();
    for (int i = 1; i <= 9; i++) rx_pulse(8'(i));
    cs_i = 1'b1;
    repeat (4) tick();
    wb_read(4'h4, d);
    total++; if (d !== 32'h0800_00B6) $display("FAIL rxovf_status: got %h expected 080000b6", d); else passed++;
    total++; if (d[27:24] !== 4'd8) $display("FAIL rxovf_level: got %0d expected 8", d[27:24]); else passed++;
    wb_read(4'hC, d);
    total++; if (d !== 32'd9) $display("FAIL rxovf_fcnt: got %h expected 9", d); else passed++;
    for (int i = 1; i <= 8; i++) begin
      wb_read(4'h0, d);
      total++; if (d !== 32'(i)) $display("FAIL rxovf_byte%0d: got %h expected %h", i, d, i); else passed++;
    end
    wb_read(4'h0, d);
    total++; if (d !== 32'h0) $display("FAIL rxovf_drained: got %h expected 0", d); else passed++;
  endtask

  task automatic test_tx_overflow();
    logic [31:0] d;
    do_reset(1'b1);
    for (int i = 0; i < 9; i++) wb_write(4'h0, 32'h10 + 32'(i));
    wb_read(4'h4, d);
    total++; if (d !== 32'h0008_0049) $display("FAIL txovf_status: got %h expected 00080049", d); else passed++;
    total++; if (irq_o !== 1'b1) $display("FAIL txovf_irq: got %b expected 1", irq_o); else passed++;
    wb_write(4'h4, 32'hF0);
    total++; if (irq_o !== 1'b1) $display("FAIL txovf_irq_lag: got %b expected 1", irq_o); else passed++;
    tick();
    total++; if (irq_o !== 1'b0) $display("FAIL txovf_irq_drop: got %b expected 0", irq_o); else passed++;
    wb_read(4'h4, d);
    total++; if (d !== 32'h0008_0009) $display("FAIL txovf_w1c_status: got %h expected 00080009", d); else passed++;
  endtask

  task automatic test_same_cycle();
    logic [31:0] d;
    // chip select rise coincident with a received byte
    do_reset(1'b1);
    wb_write(4'h8, 32'h1);
    cs_i = 1'b0;
    repeat (5) tick();
    total++; if (dv_count !== 1) $display("FAIL same_first_slot: got %0d expected 1", dv_count); else passed++;
    cs_i = 1'b1;
    tick(); tick();
    spi_rx_dv_i = 1'b1; spi_rx_byte_i = 8'h77;
    tick();
    spi_rx_dv_i = 1'b0;
    total++; if (spi_tx_dv_o !== 1'b0) $display("FAIL same_no_load: got %b expected 0", spi_tx_dv_o); else passed++;
    repeat (3) tick();
    total++; if (dv_count !== 1) $display("FAIL same_slot_count: got %0d expected 1", dv_count); else passed++;
    wb_read(4'hC, d);
    total++; if (d !== 32'd1) $display("FAIL same_fcnt: got %h expected 1", d); else passed++;
    wb_read(4'h4, d);
    total++; if (d[7] !== 1'b1) $display("FAIL same_frame_done: got %b expected 1", d[7]); else passed++;
    wb_read(4'h0, d);
    total++; if (d !== 32'h77) $display("FAIL same_rx_byte: got %h expected 77", d); else passed++;
    // DATA write and slot pop together on a full TX FIFO
    do_reset(1'b1);
    for (int i = 0; i < 8; i++) wb_write(4'h0, 32'h40 + 32'(i));
    wb_write(4'h8, 32'h1);
    cs_i = 1'b0;
    tick(); tick();
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 4'h0; wb_dat_i = 32'h99;
    tick();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    total++; if ({spi_tx_dv_o, spi_tx_byte_o} !== {1'b1, 8'h40}) $display("FAIL same_pop_byte: got %b/%h expected 1/40", spi_tx_dv_o, spi_tx_byte_o); else passed++;
    wb_read(4'h4, d);
    total++; if (d !== 32'h0008_0109) $display("FAIL same_full_status: got %h expected 00080109", d); else passed++;
    cs_i = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_disable_midframe();
    logic [31:0] d;
    do_reset(1'b1);
    wb_write(4'h8, 32'h1);
    cs_i = 1'b0;
    repeat (5) tick();
    rx_pulse(8'h55);
    total++; if (dv_count !== 2) $display("FAIL dis_slots_before: got %0d expected 2", dv_count); else passed++;
    wb_write(4'h8, 32'h0);
    rx_pulse(8'h66);
    rx_pulse(8'h67);
    total++; if (dv_count !== 2) $display("FAIL dis_no_slots: got %0d expected 2", dv_count); else passed++;
    wb_read(4'h4, d);
    total++; if (d !== 32'h0100_0122) $display("FAIL dis_status: got %h expected 01000122", d); else passed++;
    wb_read(4'hC, d);
    total++; if (d !== 32'd1) $display("FAIL dis_fcnt: got %h expected 1", d); else passed++;
    wb_write(4'h8, 32'h1);
    repeat (4) tick();
    total++; if (dv_count !== 2) $display("FAIL dis_reenable_no_slot: got %0d expected 2", dv_count); else passed++;
    cs_i = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_back_to_back();
    do_reset(1'b1);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 4'h8; wb_dat_i = 32'h6;
    tick();
    total++; if (wb_ack_o !== 1'b1) $display("FAIL b2b_ack0: got %b expected 1", wb_ack_o); else passed++;
    wb_we_i = 1'b0; wb_adr_i = 4'h8;
    tick();
    total++; if ({wb_ack_o, wb_dat_o} !== {1'b1, 32'h6}) $display("FAIL b2b_ctrl: got %b/%h expected 1/6", wb_ack_o, wb_dat_o); else passed++;
    wb_adr_i = 4'h4;
    tick();
    total++; if ({wb_ack_o, wb_dat_o} !== {1'b1, 32'h0A}) $display("FAIL b2b_status: got %b/%h expected 1/0a", wb_ack_o, wb_dat_o); else passed++;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    tick();
    total++; if (wb_ack_o !== 1'b0) $display("FAIL b2b_ack_idle: got %b expected 0", wb_ack_o); else passed++;
    total++; if (irq_o !== 1'b0) $display("FAIL b2b_irq: got %b expected 0", irq_o); else passed++;
  endtask

  initial begin
    test_reset();
    test_reset_cs_low();
    test_basic_frame();
    test_rx_overflow();
    test_tx_overflow();
    test_same_cycle();
    test_disable_midframe();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
